// File: rtl/fifo_arb_pkg.sv
// Shared types and default parameters for the FIFO write arbiter.
//   arb_state_e   : arbiter FSM state encoding
//   DEF_*         : default values for N_REQ, WIDTH and MAX_BURST
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam int unsigned DEF_N_REQ     = 4;
    localparam int unsigned DEF_WIDTH     = 8;
    localparam int unsigned DEF_MAX_BURST = 4;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of req at or after ptr,
// wrapping modulo N_REQ.
//   req   : request vector
//   ptr   : search start index
//   found : any request set
//   idx   : selected index (ptr when nothing is set)
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int unsigned N_REQ = DEF_N_REQ,
    parameter int unsigned IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic             found,
    output logic [IW-1:0]    idx
);

    // Scan from the farthest offset down so the nearest request wins.
    always_comb begin
        int c;
        c     = 0;
        found = |req;
        idx   = ptr;
        for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
            c = int'(ptr) + k;
            if (c >= int'(N_REQ)) c = c - int'(N_REQ);
            if (req[IW'(c)]) idx = IW'(c);
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter merging N_REQ producer streams into one FIFO write port.
// A granted producer keeps the port for up to MAX_BURST beats, until its
// req_last beat, or until it drops req_valid.
// Optional feature: define FIFO_WR_ARBITER_STATS_EN to add per-producer
// saturating grant counters on grant_cnt.
//   clk, reset_n : clock (rising edge), async active-low reset
//   req_valid    : per-producer beat valid
//   req_data     : producer i data at [i*WIDTH +: WIDTH]
//   req_last     : per-producer end of packet
//   req_ready    : per-producer accept (combinational from full)
//   full         : shared FIFO full flag
//   wr_en/data_o : registered FIFO write strobe and data
//   grant_id     : current owner index
//   busy         : high while a burst is in progress
//   grant_cnt    : (stats build only) 16-bit grant count per producer
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned N_REQ     = DEF_N_REQ,
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned MAX_BURST = DEF_MAX_BURST
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*WIDTH-1:0]     req_data,
    input  logic [N_REQ-1:0]           req_last,
    output logic [N_REQ-1:0]           req_ready,
    input  logic                       full,
    output logic                       wr_en,
    output logic [WIDTH-1:0]           data_o,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       busy
`ifdef FIFO_WR_ARBITER_STATS_EN
    ,
    output logic [N_REQ*16-1:0]        grant_cnt
`endif
);

    localparam int unsigned IW = $clog2(N_REQ);
    localparam int unsigned CW = $clog2(MAX_BURST + 1);

    arb_state_e       r_state, w_state_nxt;
    logic [IW-1:0]    r_grant_id, w_grant_id_nxt;
    logic [IW-1:0]    r_rr_ptr, w_rr_ptr_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt, w_cnt_inc;
    logic             r_wr_en;
    logic [WIDTH-1:0] r_data;
    logic [N_REQ-1:0] w_ready;
    logic             w_xfer, w_grant, w_found;
    logic [IW-1:0]    w_pick_idx;
    logic             w_valid_g, w_last_g;
    logic [WIDTH-1:0] w_beat;

    rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_rr_pick (
        .req   (req_valid),
        .ptr   (r_rr_ptr),
        .found (w_found),
        .idx   (w_pick_idx)
    );

    // Owner's valid/last/data.
    always_comb begin
        w_valid_g = req_valid[r_grant_id];
        w_last_g  = req_last[r_grant_id];
        w_beat    = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (r_grant_id == IW'(i)) w_beat = req_data[i*WIDTH +: WIDTH];
        end
    end

    assign w_cnt_inc = r_cnt + CW'(1);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next state, grant bookkeeping and ready.
    always_comb begin
        w_state_nxt    = r_state;
        w_grant_id_nxt = r_grant_id;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_cnt_nxt      = r_cnt;
        w_ready        = '0;
        w_xfer         = 1'b0;
        w_grant        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_found && !full) begin
                    w_state_nxt    = BURST;
                    w_grant_id_nxt = w_pick_idx;
                    w_cnt_nxt      = '0;
                    w_grant        = 1'b1;
                end
            end
            BURST: begin
                w_ready[r_grant_id] = !full;
                w_xfer              = w_valid_g && !full;
                if (w_xfer) w_cnt_nxt = w_cnt_inc;
                // Full alone only stalls; a dropped valid ends the burst.
                if (!w_valid_g ||
                    (w_xfer && (w_last_g || w_cnt_inc == CW'(MAX_BURST)))) begin
                    w_state_nxt  = IDLE;
                    w_rr_ptr_nxt = (r_grant_id == IW'(N_REQ - 1)) ? '0
                                                                  : r_grant_id + IW'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath and arbitration registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_grant_id <= '0;
            r_rr_ptr   <= '0;
            r_cnt      <= '0;
            r_wr_en    <= 1'b0;
            r_data     <= '0;
        end else begin
            r_grant_id <= w_grant_id_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_cnt      <= w_cnt_nxt;
            r_wr_en    <= w_xfer;
            if (w_xfer) r_data <= w_beat;
        end
    end

    assign req_ready = w_ready;
    assign wr_en     = r_wr_en;
    assign data_o    = r_data;
    assign grant_id  = r_grant_id;
    assign busy      = (r_state == BURST);

`ifdef FIFO_WR_ARBITER_STATS_EN
    logic [15:0] r_grant_cnt [N_REQ];

    // Saturating per-producer grant counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(N_REQ); i++) r_grant_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < int'(N_REQ); i++) begin
                if (w_grant && w_pick_idx == IW'(i) && r_grant_cnt[i] != 16'hFFFF)
                    r_grant_cnt[i] <= r_grant_cnt[i] + 16'd1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < int'(N_REQ); i++) grant_cnt[i*16 +: 16] = r_grant_cnt[i];
    end
`endif

endmodule
